// File: rtl/core_pkg.sv
//------------------------------------------------------------------------------
// Module  : core_pkg
// Purpose : Shared definitions for the RV32I core PC and branch logic.
//           Holds the branch funct3 encodings, the fetch-side state enum and
//           the sequential PC step.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package core_pkg;

  // Branch comparison encodings carried in funct3
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Byte distance between consecutive 32-bit instructions
  localparam logic [31:0] PC_STEP = 32'd4;

  // Fetch-side state
  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    TRAP = 2'b10
  } pc_state_t;

endpackage : core_pkg

`default_nettype wire

// File: rtl/branch_cond.sv
//------------------------------------------------------------------------------
// Module  : branch_cond
// Purpose : Purely combinational branch condition evaluation. Maps funct3
//           and the ALU compare flags (rs1 vs rs2) to a single cond bit.
//           Shared with the hazard unit.
// Ports   : funct3   in  3  branch type
//           alu_zero in  1  rs1 == rs2
//           alu_lt   in  1  rs1 <  rs2 (signed)
//           alu_ltu  in  1  rs1 <  rs2 (unsigned)
//           cond     out 1  branch condition satisfied
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module branch_cond
  import core_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       alu_zero,
  input  logic       alu_lt,
  input  logic       alu_ltu,
  output logic       cond
);

  always_comb begin
    cond = 1'b0;
    unique case (funct3)
      F3_BEQ:  cond =  alu_zero;
      F3_BNE:  cond = ~alu_zero;
      F3_BLT:  cond =  alu_lt;
      F3_BGE:  cond = ~alu_lt;
      F3_BLTU: cond =  alu_ltu;
      F3_BGEU: cond = ~alu_ltu;
      // 010 and 011 are not branch encodings; never taken
      default: cond = 1'b0;
    endcase
  end

endmodule : branch_cond

`default_nettype wire

// File: rtl/branch_pc_unit.sv
//------------------------------------------------------------------------------
// Module  : branch_pc_unit
// Purpose : Program-counter and branch-target stage. Resolves branch, JAL and
//           JALR in EX, owns the fetch PC register and presents it to
//           instruction memory with a valid/ready handshake.
// Ports   : clk, rst_n                 clock, async active-low reset
//           op_shift_left  in  32      B/J-type byte offset (imm << 1)
//           imm            in  32      I-type immediate (JALR only)
//           rs1_data       in  32      JALR base
//           ex_pc          in  32      PC of the EX instruction
//           ex_valid       in  1       EX holds a real instruction
//           is_branch/is_jal/is_jalr   one-hot control from decode
//           funct3         in  3       branch type
//           alu_zero/lt/ltu            compare flags
//           fetch_ready    in  1       imem accepts fetch_pc
//           fetch_pc       out 32      fetch address
//           fetch_valid    out 1       fetch request valid
//           flush          out 1       kill IF/ID (combinational)
//           link_addr      out 32      ex_pc + 4
//           misalign       out 1       sticky misaligned-target trap
//           taken_count    out 32      saturating redirect counter
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module branch_pc_unit
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] op_shift_left,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_data,
  input  logic [31:0] ex_pc,
  input  logic        ex_valid,
  input  logic        is_branch,
  input  logic        is_jal,
  input  logic        is_jalr,
  input  logic [2:0]  funct3,
  input  logic        alu_zero,
  input  logic        alu_lt,
  input  logic        alu_ltu,
  input  logic        fetch_ready,
  output logic [31:0] fetch_pc,
  output logic        fetch_valid,
  output logic        flush,
  output logic [31:0] link_addr,
  output logic        misalign,
  output logic [31:0] taken_count
);

  pc_state_t   r_state;
  pc_state_t   w_state_nxt;
  logic [31:0] r_fetch_pc;
  logic [31:0] w_fetch_pc_nxt;
  logic [31:0] r_taken_count;
  logic        w_count_inc;

  logic        w_cond;
  logic        w_taken;
  logic [31:0] w_jalr_sum;
  logic [31:0] w_target;
  logic [31:0] w_next_seq;

  branch_cond u_branch_cond (
    .funct3   (funct3),
    .alu_zero (alu_zero),
    .alu_lt   (alu_lt),
    .alu_ltu  (alu_ltu),
    .cond     (w_cond)
  );

  assign w_taken    = ex_valid & (is_jal | is_jalr | (is_branch & w_cond));
  assign w_jalr_sum = rs1_data + imm;
  // JALR clears bit 0 of the sum; branch and JAL are PC-relative
  assign w_target   = is_jalr ? (w_jalr_sum & ~32'h1) : (ex_pc + op_shift_left);
  assign w_next_seq = r_fetch_pc + PC_STEP;

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_count_inc    = 1'b0;
    flush          = 1'b0;
    unique case (r_state)
      BOOT: begin
        w_state_nxt = RUN;
      end
      RUN: begin
        // Redirect wins over a stalled fetch
        if (w_taken) begin
          flush = 1'b1;
          if (w_target[1]) begin
            w_state_nxt = TRAP;
          end else begin
            w_fetch_pc_nxt = w_target;
            w_count_inc    = 1'b1;
          end
        end else if (fetch_ready) begin
          w_fetch_pc_nxt = w_next_seq;
        end
      end
      TRAP: begin
        w_state_nxt = TRAP;
      end
      default: begin
        w_state_nxt = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= BOOT;
      r_fetch_pc    <= RESET_VECTOR;
      r_taken_count <= 32'h0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      if (w_count_inc && (r_taken_count != 32'hFFFF_FFFF)) begin
        r_taken_count <= r_taken_count + 32'd1;
      end
    end
  end

  assign fetch_pc    = r_fetch_pc;
  assign fetch_valid = (r_state == RUN);
  assign misalign    = (r_state == TRAP);
  assign taken_count = r_taken_count;
  assign link_addr   = ex_pc + PC_STEP;

endmodule : branch_pc_unit

`default_nettype wire

// File: doc/branch_pc_unit.md
# branch_pc_unit

Program-counter and branch-target stage of the RV32I core. It sits directly downstream of the immediate shift stage. It consumes the left-shifted B/J-type immediate, the EX-stage PC and the ALU compare flags, and resolves the branch, JAL or JALR outcome. It owns the fetch PC register and drives it to instruction memory with a valid/ready handshake.

## Interface
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  reset; asynchronous and active-low
- op_shift_left  in  32  immediate << 1, the B/J-type byte offset
- imm  in  32  raw sign-extended I-type immediate, used only by JALR
- rs1_data  in  32  JALR base register value
- ex_pc  in  32  PC of the instruction currently in EX
- ex_valid  in  1  EX holds a real instruction this cycle
- is_branch, is_jal, is_jalr  in  1 each  one-hot control from decode (at most one is high)
- funct3  in  3  branch type: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU
- alu_zero, alu_lt, alu_ltu  in  1 each  compare flags for rs1 vs rs2
- fetch_ready  in  1  instruction memory accepts fetch_pc this cycle
- fetch_pc  out  32  current fetch address
- fetch_valid  out  1  fetch_pc is a valid request
- flush  out  1  kill the IF/ID instructions this cycle (combinational)
- link_addr  out  32  ex_pc + 4, written to rd by JAL/JALR
- misalign  out  1  sticky instruction-address-misaligned trap
- taken_count  out  32  count of redirects taken since reset

## Operation
- taken = ex_valid & (is_jal | is_jalr | (is_branch & cond)).
- cond by funct3:
  - BEQ zero; BNE ~zero; BLT lt; BGE ~lt; BLTU ltu; BGEU ~ltu.
  - funct3 010 and 011 give cond = 0.
- Target:
  - branch and JAL: ex_pc + op_shift_left.
  - JALR: (rs1_data + imm) & ~32'h1.
  - All adds are modulo 2^32; wrap-around is silent.
- Sequential PC, next_seq = fetch_pc + 4, modulo 2^32.
- States:
  - BOOT: entered on reset. Lasts exactly 1 cycle with fetch_valid = 0, then goes to RUN.
  - RUN: normal operation, fetch_valid = 1.
  - TRAP: fetch_valid = 0 and misalign = 1. Left only by reset.
- Transitions in RUN:
  - taken and target[1] = 1: go to TRAP. fetch_pc is unchanged and flush = 1.
  - taken and target aligned: fetch_pc <= target, flush = 1, taken_count += 1.
  - not taken and fetch_ready = 1: fetch_pc <= next_seq.
  - not taken and fetch_ready = 0: fetch_pc holds.
- Redirect has priority over stall. A taken branch while fetch_ready = 0 still loads target.
- taken_count saturates at 32'hFFFF_FFFF.
- flush is forced to 0 whenever ex_valid = 0, and in BOOT and TRAP.

## Timing
- Reset values: fetch_pc = RESET_VECTOR, fetch_valid = 0, flush = 0, misalign = 0, taken_count = 0, state = BOOT.
- Reset assertion takes effect immediately, even mid-redirect. No partial update survives.
- Resolution latency:
  - flush is asserted in the same cycle as taken.
  - The new fetch_pc is visible on the next rising edge.
  - Penalty is 2 bubbles, the killed IF and ID slots.
- Handshake: a fetch transfers when fetch_valid & fetch_ready at a rising edge. While stalled, fetch_pc and fetch_valid stay stable unless a redirect occurs.
- link_addr is purely combinational from ex_pc.
- First fetch of RESET_VECTOR completes no earlier than the 2nd edge after reset release.

## Structure
- Shared package core_pkg holds:
  - funct3 branch encodings (F3_BEQ … F3_BGEU)
  - state enum (BOOT/RUN/TRAP)
  - constant PC_STEP = 4
- One sub-module, branch_cond: purely combinational funct3 plus flags to cond. It is reused by the hazard unit.
- The adders and the PC register stay inline.

## Test plan
- Reset release: fetch_valid 0 for the BOOT cycle, then fetch_pc sequence 0x0, 0x4, 0x8 with fetch_ready = 1.
- BEQ taken: ex_pc = 0x100, op_shift_left = 0x20, alu_zero = 1. Expect flush = 1 that cycle, fetch_pc = 0x120 next cycle, taken_count = 1.
- Not taken and variants:
  - BNE with alu_zero = 1: no flush, PC continues +4.
  - BLTU with alu_ltu = 1 and op_shift_left = 0xFFFF_FFF8 from ex_pc = 0x10: target 0x8.
- JALR: rs1_data = 0x1003, imm = 0x4. Target 0x1006 has bit 1 set, so expect misalign = 1 and fetch_valid = 0; both stay until rst_n pulse.
- JALR with rs1_data = 0x2001, imm = 0: target 0x2000, link_addr = ex_pc + 4.
- Stall plus redirect: fetch_ready = 0 for 3 cycles, JAL taken in the 2nd. fetch_pc loads the target and holds while stalled. Drop rst_n mid-stall and check all outputs return to reset values immediately.
